esdi_serial_ctrl: RTL and testbench
===================================

# esdi_serial_ctrl

Bit-serial ESDI command/status sequencer between the (already polarity-corrected) ESDI interface pins and the drive command processor. Shifts in 17-bit commands (16 data + odd parity) over the transfer_req/transfer_ack handshake, presents them as a parallel word, then shifts a 16-bit status/config response back out on confstat_data. Also owns command_complete and attention for the emulated drive.

## Interface
- ACK_DELAY, 4: clk cycles between capturing/presenting a bit and asserting transfer_ack (1..255).
- TIMEOUT, 1_000_000: clk cycles of idle req inside a partial word before abort (>= 16).
- clk  in  1  system clock; the only clock.
- resetn  in  1  asynchronous, active-low reset.
- esdi_transfer_req  in  1  host handshake, active-high, asynchronous to clk.
- esdi_command_data  in  1  host command bit, active-high, asynchronous.
- esdi_transfer_ack  out  1  drive handshake.
- esdi_confstat_data  out  1  drive status/config bit.
- esdi_command_complete  out  1  high when no command is in progress.
- esdi_attention  out  1  fault/parity attention.
- cmd_word  out  16  received command, valid while cmd_valid.
- cmd_valid  out  1  command word available.
- cmd_ready  in  1  processor accepts cmd_word.
- rsp_valid  in  1  processor response ready.
- rsp_has_data  in  1  with rsp_valid: 1 = shift rsp_word out, 0 = no data phase.
- rsp_word  in  16  response/status word.
- attn_clear  in  1  one-cycle pulse clears attention.
- err_parity  out  1  sticky: last command failed parity; cleared by attn_clear.
- err_timeout  out  1  sticky: partial word aborted; cleared by attn_clear.

## Operation
- req and command_data pass through 2-flop synchronizers; all logic uses synchronized copies (rq, cd).
- States: IDLE, C_ACK, C_REL, EXEC, RSP, S_SETUP, S_ACK, S_REL.
- IDLE: rq rising -> capture cd into shift register (MSB first: bits 15..0 then parity), count++, command_complete low, -> C_ACK.
- C_ACK: wait ACK_DELAY, assert ack -> C_REL. C_REL: rq low -> ack low; if count < 17 -> IDLE-wait-for-next-bit (stay in command phase); count == 17 -> check parity.
- Parity: ones in 17 bits must be odd. Fail -> err_parity=1, attention=1, command discarded, command_complete high, -> IDLE. Pass -> cmd_valid=1, -> EXEC.
- EXEC: cmd_valid && cmd_ready handshake -> cmd_valid low -> RSP.
- RSP: rsp_valid with rsp_has_data=0 -> command_complete high, -> IDLE. With 1 -> latch rsp_word, compute odd parity bit, -> S_SETUP.
- S_SETUP: wait rq rising; drive confstat_data = current bit (MSB first, parity last), ACK_DELAY, assert ack (S_ACK); rq low -> ack low (S_REL); after 17 bits command_complete high, -> IDLE.
- Timeout counter runs whenever 0 < bit count < 17 and state waits for rq rising; at TIMEOUT: err_timeout=1, attention=1, count=0, ack low, command_complete high, -> IDLE. Not active in EXEC/RSP.
- attn_clear clears attention, err_parity, err_timeout; simultaneous new error wins (stays set).
- rq dropping before ack asserted: ack still asserts after ACK_DELAY, then released next cycle (bit counts).

## Timing
- Reset: ack 0, confstat_data 0, command_complete 1, attention 0, cmd_valid 0, cmd_word 0, err flags 0, state IDLE, count 0.
- Bit capture: 2 cycles after pin edge (sync) + 1 register; ack high ACK_DELAY cycles after capture; ack low 1 cycle after synchronized rq low (3 cycles from pin).
- command_complete falls in the cycle the first bit is captured; rises 1 cycle after final ack release (or abort/parity fail).
- cmd_valid rises 1 cycle after 17th ack released; held with cmd_word stable until cmd_ready.
- confstat_data stable from ACK_DELAY cycles before ack rise until next bit loads after ack release.
- Reset mid-operation: immediate return to reset values; no partial word survives.

## Structure
- Package esdi_pkg: state enum, CMD_BITS=16, FRAME_BITS=17, parity function.
- Sub-module esdi_sync (2-flop synchronizer, parameter WIDTH), instantiated for req and command_data.

## Test plan
- Command 0x1234 (parity bit 0, five ones) with 17 req/ack cycles -> cmd_word=0x1234, cmd_valid, command_complete low until rsp_valid with rsp_has_data=0.
- Command 0x1234 with parity bit 1 -> err_parity=1, attention=1, no cmd_valid, command_complete high; attn_clear -> all clear.
- Command accepted, rsp_word=0x00FF, rsp_has_data=1 -> 17 host reads return 0,0,0,0,0,0,0,0,1×8, parity 1.
- 9 bits then no req for TIMEOUT cycles -> err_timeout=1, attention=1, next 17-bit command 0xA5A5 received correctly.
- ACK_DELAY=4: measure req pin edge to ack rise = 7 cycles; req fall to ack fall = 3 cycles.
- resetn asserted after bit 8 -> all outputs reset values; fresh command 0x0001 received intact.

Source files
------------

// File: rtl/esdi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : esdi_pkg
//  Description : Shared types, frame sizes and parity helpers for the ESDI
//                serial command/status sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package esdi_pkg;

    localparam int CMD_BITS   = 16;
    localparam int FRAME_BITS = 17;
    localparam int CNT_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_C_ACK   = 3'd1,
        ST_C_REL   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_RSP     = 3'd4,
        ST_S_SETUP = 3'd5,
        ST_S_ACK   = 3'd6,
        ST_S_REL   = 3'd7
    } esdi_state_t;

    // A frame is good when the total number of ones (data + parity) is odd.
    function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] frame);
        return ^frame;
    endfunction

    // Parity bit that makes {word, bit} carry an odd number of ones.
    function automatic logic odd_parity_bit(input logic [CMD_BITS-1:0] word);
        return ~(^word);
    endfunction

endpackage
`default_nettype wire

// File: rtl/esdi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : esdi_sync
//  Description : Two-flop synchronizer bringing asynchronous ESDI pins into
//                the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module esdi_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/esdi_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : esdi_serial_ctrl
//  Description : Bit-serial ESDI command/status sequencer. Shifts in 17-bit
//                commands over transfer_req/transfer_ack, hands the word to
//                the drive command processor, and shifts the 16-bit response
//                plus odd parity back out on confstat_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module esdi_serial_ctrl
    import esdi_pkg::*;
#(
    parameter int ACK_DELAY = 4,
    parameter int TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        esdi_transfer_req,
    input  logic        esdi_command_data,
    output logic        esdi_transfer_ack,
    output logic        esdi_confstat_data,
    output logic        esdi_command_complete,
    output logic        esdi_attention,
    output logic [15:0] cmd_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        rsp_valid,
    input  logic        rsp_has_data,
    input  logic [15:0] rsp_word,
    input  logic        attn_clear,
    output logic        err_parity,
    output logic        err_timeout
);

    localparam int                TMO_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  c_last_bit = CNT_W'(FRAME_BITS);
    localparam logic [7:0]        c_ack_dly  = 8'(ACK_DELAY);
    localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TIMEOUT - 1);

    logic w_rq;
    logic w_cd;
    logic w_rq_rise;
    logic w_mid_frame;

    esdi_state_t r_state, w_state_nxt;

    logic [CNT_W-1:0]      r_cnt,        w_cnt_nxt;
    logic [7:0]            r_dly,        w_dly_nxt;
    logic [TMO_W-1:0]      r_tmo,        w_tmo_nxt;
    logic [FRAME_BITS-1:0] r_shift,      w_shift_nxt;
    logic [FRAME_BITS-1:0] r_rsp,        w_rsp_nxt;
    logic                  r_ack,        w_ack_nxt;
    logic                  r_confstat,   w_confstat_nxt;
    logic                  r_cc,         w_cc_nxt;
    logic                  r_cmd_valid,  w_cmd_valid_nxt;
    logic [CMD_BITS-1:0]   r_cmd_word,   w_cmd_word_nxt;
    logic                  r_attn,       w_attn_nxt;
    logic                  r_err_par,    w_err_par_nxt;
    logic                  r_err_tmo,    w_err_tmo_nxt;
    logic                  r_rq_d;

    esdi_sync #(.WIDTH(1)) u_sync_req (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (esdi_transfer_req),
        .o_q    (w_rq)
    );

    esdi_sync #(.WIDTH(1)) u_sync_cd (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (esdi_command_data),
        .o_q    (w_cd)
    );

    assign w_rq_rise   = w_rq & ~r_rq_d;
    assign w_mid_frame = (r_cnt != '0);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_dly       <= '0;
            r_tmo       <= '0;
            r_shift     <= '0;
            r_rsp       <= '0;
            r_ack       <= 1'b0;
            r_confstat  <= 1'b0;
            r_cc        <= 1'b1;
            r_cmd_valid <= 1'b0;
            r_cmd_word  <= '0;
            r_attn      <= 1'b0;
            r_err_par   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_rq_d      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_dly       <= w_dly_nxt;
            r_tmo       <= w_tmo_nxt;
            r_shift     <= w_shift_nxt;
            r_rsp       <= w_rsp_nxt;
            r_ack       <= w_ack_nxt;
            r_confstat  <= w_confstat_nxt;
            r_cc        <= w_cc_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_word  <= w_cmd_word_nxt;
            r_attn      <= w_attn_nxt;
            r_err_par   <= w_err_par_nxt;
            r_err_tmo   <= w_err_tmo_nxt;
            r_rq_d      <= w_rq;
        end
    end

    // Next-state and register update logic for both serial phases.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_dly_nxt       = r_dly;
        w_tmo_nxt       = '0;
        w_shift_nxt     = r_shift;
        w_rsp_nxt       = r_rsp;
        w_ack_nxt       = r_ack;
        w_confstat_nxt  = r_confstat;
        w_cc_nxt        = r_cc;
        w_cmd_valid_nxt = r_cmd_valid;
        w_cmd_word_nxt  = r_cmd_word;
        w_attn_nxt      = r_attn;
        w_err_par_nxt   = r_err_par;
        w_err_tmo_nxt   = r_err_tmo;

        // Clear first so an error raised in the same cycle overrides it.
        if (attn_clear) begin
            w_attn_nxt    = 1'b0;
            w_err_par_nxt = 1'b0;
            w_err_tmo_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE, ST_S_SETUP: begin
                if (w_rq_rise) begin
                    if (r_state == ST_IDLE) begin
                        w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_cd};
                        w_cc_nxt    = 1'b0;
                        w_state_nxt = ST_C_ACK;
                    end else begin
                        w_confstat_nxt = r_rsp[FRAME_BITS-1];
                        w_rsp_nxt      = {r_rsp[FRAME_BITS-2:0], 1'b0};
                        w_state_nxt    = ST_S_ACK;
                    end
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_dly_nxt = 8'd1;
                end else if (w_mid_frame) begin
                    // Host went quiet inside a partial word: abandon it.
                    if (r_tmo == c_tmo_last) begin
                        w_err_tmo_nxt = 1'b1;
                        w_attn_nxt    = 1'b1;
                        w_cnt_nxt     = '0;
                        w_ack_nxt     = 1'b0;
                        w_cc_nxt      = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_tmo_nxt = r_tmo + 1'b1;
                    end
                end
            end

            ST_C_ACK, ST_S_ACK: begin
                if (r_dly == c_ack_dly) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = (r_state == ST_C_ACK) ? ST_C_REL : ST_S_REL;
                end else begin
                    w_dly_nxt = r_dly + 1'b1;
                end
            end

            ST_C_REL: begin
                if (r_ack) begin
                    if (!w_rq) begin
                        w_ack_nxt = 1'b0;
                        if (r_cnt != c_last_bit) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    // Last bit released one cycle ago: judge the frame.
                    w_cnt_nxt = '0;
                    if (frame_parity_ok(r_shift)) begin
                        w_cmd_word_nxt  = r_shift[FRAME_BITS-1:1];
                        w_cmd_valid_nxt = 1'b1;
                        w_state_nxt     = ST_EXEC;
                    end else begin
                        w_err_par_nxt = 1'b1;
                        w_attn_nxt    = 1'b1;
                        w_cc_nxt      = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end

            ST_EXEC: begin
                if (cmd_ready) begin
                    w_cmd_valid_nxt = 1'b0;
                    w_state_nxt     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (rsp_valid) begin
                    if (rsp_has_data) begin
                        w_rsp_nxt   = {rsp_word, odd_parity_bit(rsp_word)};
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_S_SETUP;
                    end else begin
                        w_cc_nxt    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_S_REL: begin
                if (r_ack) begin
                    if (!w_rq) begin
                        w_ack_nxt = 1'b0;
                        if (r_cnt != c_last_bit) begin
                            w_state_nxt = ST_S_SETUP;
                        end
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_cc_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign esdi_transfer_ack     = r_ack;
    assign esdi_confstat_data    = r_confstat;
    assign esdi_command_complete = r_cc;
    assign esdi_attention        = r_attn;
    assign cmd_word              = r_cmd_word;
    assign cmd_valid             = r_cmd_valid;
    assign err_parity            = r_err_par;
    assign err_timeout           = r_err_tmo;

endmodule
`default_nettype wire

// File: tb/tb_esdi_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esdi_serial_ctrl
//  Description : Self-checking bench for esdi_serial_ctrl: acts as ESDI host
//                and command processor, predicts results from frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_esdi_serial_ctrl;

    localparam int ACK_DELAY = 4;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        cdata = 1'b0;
    logic        ack;
    logic        confstat;
    logic        cmd_complete;
    logic        attention;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic        rsp_has_data = 1'b0;
    logic [15:0] rsp_word = '0;
    logic        attn_clear = 1'b0;
    logic        err_parity;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    esdi_serial_ctrl #(.ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .esdi_transfer_req     (req),
        .esdi_command_data     (cdata),
        .esdi_transfer_ack     (ack),
        .esdi_confstat_data    (confstat),
        .esdi_command_complete (cmd_complete),
        .esdi_attention        (attention),
        .cmd_word              (cmd_word),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .rsp_valid             (rsp_valid),
        .rsp_has_data          (rsp_has_data),
        .rsp_word              (rsp_word),
        .attn_clear            (attn_clear),
        .err_parity            (err_parity),
        .err_timeout           (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (ack === level) return;
        end
        chk("ack_wait", 32'(ack), 32'(level));
    endtask

    // One host transfer; returns data seen at ack and pin-to-ack latencies.
    task automatic host_bit(input logic b, output logic rd, output int t_r, output int t_f);
        cdata = b;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        req = 1'b1;
        wait_ack(1'b1, t_r);
        rd  = confstat;
        req = 1'b0;
        wait_ack(1'b0, t_f);
    endtask

    task automatic send_bits(input logic [16:0] frame, input int nbits,
                             output int t_r0, output int t_f0);
        logic rd;
        int   tr, tf;
        t_r0 = 0;
        t_f0 = 0;
        for (int i = 0; i < nbits; i++) begin
            host_bit(frame[16-i], rd, tr, tf);
            if (i == 0) begin
                t_r0 = tr;
                t_f0 = tf;
            end
        end
    endtask

    task automatic read_frame(output logic [16:0] got);
        logic rd;
        int   tr, tf;
        got = '0;
        for (int i = 0; i < 17; i++) begin
            host_bit(1'b0, rd, tr, tf);
            got = {got[15:0], rd};
        end
    endtask

    // Outcome of a complete frame, judged from the odd-ones rule.
    task automatic expect_cmd(input logic [16:0] frame);
        logic good;
        good = ($countones(frame) % 2) == 1;
        @(negedge clk);
        if (good) begin
            chk("cmd_valid", 32'(cmd_valid), 1);
            chk("cmd_word", 32'(cmd_word), 32'(frame[16:1]));
            chk("cc_busy", 32'(cmd_complete), 0);
            chk("no_perr", 32'(err_parity), 0);
        end else begin
            chk("perr", 32'(err_parity), 1);
            chk("perr_attn", 32'(attention), 1);
            chk("perr_novalid", 32'(cmd_valid), 0);
            chk("perr_cc", 32'(cmd_complete), 1);
        end
    endtask

    task automatic clear_attn();
        attn_clear = 1'b1;
        @(negedge clk);
        attn_clear = 1'b0;
        chk("clr_attn", 32'(attention), 0);
        chk("clr_perr", 32'(err_parity), 0);
        chk("clr_terr", 32'(err_timeout), 0);
    endtask

    // Command processor: accept the word, then answer with or without data.
    task automatic serve(input logic has_data, input logic [15:0] r);
        logic [16:0] got;
        logic [16:0] exp;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        chk("cmd_held", 32'(cmd_valid), 1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("valid_drop", 32'(cmd_valid), 0);
        chk("cc_exec", 32'(cmd_complete), 0);
        rsp_valid    = 1'b1;
        rsp_has_data = has_data;
        rsp_word     = r;
        @(negedge clk);
        rsp_valid    = 1'b0;
        rsp_has_data = 1'b0;
        if (has_data) begin
            chk("cc_busy_rsp", 32'(cmd_complete), 0);
            read_frame(got);
            exp = {r, ($countones(r) % 2) == 0};
            chk("rsp_frame", 32'(got), 32'(exp));
            @(negedge clk);
        end
        chk("cc_done", 32'(cmd_complete), 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tr, tf;
        logic [16:0] frame;
        logic [15:0] w;
        logic        p;

        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_confstat", 32'(confstat), 0);
        chk("rst_cc", 32'(cmd_complete), 1);
        chk("rst_attn", 32'(attention), 0);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_word", 32'(cmd_word), 0);
        chk("rst_perr", 32'(err_parity), 0);
        chk("rst_terr", 32'(err_timeout), 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Good command 0x1234 with latency measurement on the first bit.
        frame = {16'h1234, 1'b0};
        send_bits(frame, 17, tr, tf);
        chk("req_to_ack_rise", 32'(tr), 7);
        chk("req_to_ack_fall", 32'(tf), 3);
        expect_cmd(frame);
        serve(1'b0, 16'h0000);

        // Same word, wrong parity.
        frame = {16'h1234, 1'b1};
        send_bits(frame, 17, tr, tf);
        expect_cmd(frame);
        clear_attn();

        // Response with data 0x00FF.
        frame = {16'h0F0F, 1'b1};
        send_bits(frame, 17, tr, tf);
        expect_cmd(frame);
        serve(1'b1, 16'h00FF);

        // Partial word of 9 bits, then silence.
        frame = {16'hFFFF, 1'b1};
        send_bits(frame, 9, tr, tf);
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("tmo_early", 32'(err_timeout), 0);
        @(negedge clk);
        chk("tmo_err", 32'(err_timeout), 1);
        chk("tmo_attn", 32'(attention), 1);
        chk("tmo_cc", 32'(cmd_complete), 1);
        clear_attn();
        frame = {16'hA5A5, 1'b1};
        send_bits(frame, 17, tr, tf);
        expect_cmd(frame);
        serve(1'b0, 16'h0000);

        // Reset in the middle of a command.
        frame = {16'h8001, 1'b1};
        send_bits(frame, 8, tr, tf);
        resetn = 1'b0;
        #1;
        chk("mrst_ack", 32'(ack), 0);
        chk("mrst_confstat", 32'(confstat), 0);
        chk("mrst_cc", 32'(cmd_complete), 1);
        chk("mrst_valid", 32'(cmd_valid), 0);
        chk("mrst_word", 32'(cmd_word), 0);
        chk("mrst_attn", 32'(attention), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        frame = {16'h0001, 1'b0};
        send_bits(frame, 17, tr, tf);
        expect_cmd(frame);
        serve(1'b0, 16'h0000);

        // Randomized traffic: mostly good parity, mixed response kinds.
        for (int it = 0; it < 20; it++) begin
            w = 16'($urandom);
            p = (($countones(w) % 2) == 0);
            if ($urandom_range(0, 3) == 0) p = ~p;
            frame = {w, p};
            send_bits(frame, 17, tr, tf);
            expect_cmd(frame);
            if (($countones(frame) % 2) == 1) begin
                serve(1'($urandom_range(0, 1)), 16'($urandom));
            end else begin
                clear_attn();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
